send_lane_arbiter: RTL

Round-robin scheduler that shares the single send controller between NUM_REQ lane requesters. Each requester asks to send one packet (source/destination address plus destination DFX). The arbiter grants one requester at a time and drives a one-cycle start request into the send controller. It then holds the request fields stable until the send path reports completion (or a watchdog expires) and returns done/error to the granted lane.

---
 rtl/send_arb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/send_lane_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/send_arb_pkg.sv
// Shared types and default widths for the send-lane arbiter and its round-robin picker.
package send_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      ISSUE     = 2'b01,
      WAIT_DONE = 2'b10,
      GAP       = 2'b11
   } send_arb_state_e;

   localparam int unsigned ADDR_WIDTH_DEF = 10;
   localparam int unsigned DFX_WIDTH_DEF  = 2;
   localparam int unsigned NUM_REQ_DEF    = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from last_grant+1.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] last_grant,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx,
   output logic                       grant_valid
);
   localparam int unsigned IW = $clog2(NUM_REQ);

   always_comb begin
      logic [IW-1:0] cand;
      cand        = '0;
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      // NUM_REQ is a power of two, so the index wraps by truncation.
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = last_grant + IW'(i);
         if (!grant_valid && req[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
      grant[grant_idx] = grant_valid;
   end

endmodule

// File: rtl/send_lane_arbiter.sv
// Shares one send controller among NUM_REQ lanes with round-robin grants.
// Optional watchdog in WAIT_DONE is enabled by defining SEND_ARB_TIMEOUT_EN.
module send_lane_arbiter
   import send_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
   parameter int unsigned DFX_WIDTH      = DFX_WIDTH_DEF,
   parameter int unsigned NUM_REQ        = NUM_REQ_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DFX_WIDTH-1:0]          local_dfx,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_src_addr,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_dst_addr,
   input  logic [NUM_REQ*DFX_WIDTH-1:0]  req_dst_dfx,
   output logic [NUM_REQ-1:0]            req_ack,
   output logic [NUM_REQ-1:0]            req_done,
   output logic [NUM_REQ-1:0]            req_err,
   output logic                          router_start_req,
   output logic [ADDR_WIDTH-1:0]         router_scr_addr,
   output logic [ADDR_WIDTH-1:0]         router_dst_addr,
   output logic [DFX_WIDTH-1:0]          router_src_dfx,
   output logic [DFX_WIDTH-1:0]          router_dst_dfx,
   input  logic                          router_send_done,
   output logic                          busy
);
   localparam int unsigned IW = $clog2(NUM_REQ);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   send_arb_state_e    state;
   logic [IW-1:0]      last_grant;
   logic [NUM_REQ-1:0] grant_oh;
   logic [NUM_REQ-1:0] pick_oh;
   logic [IW-1:0]      pick_idx;
   logic               pick_valid;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .req         (req_valid),
      .last_grant  (last_grant),
      .grant       (pick_oh),
      .grant_idx   (pick_idx),
      .grant_valid (pick_valid)
   );

   assign busy = (state != IDLE);

`ifdef SEND_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CW-1:0] wdog;
   logic          expired;

   assign expired = (wdog == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog <= '0;
      end else if (state != WAIT_DONE) begin
         wdog <= '0;
      end else if (wdog != '1) begin
         wdog <= wdog + 1'b1;
      end
   end
`else
   assign req_err = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         last_grant       <= IW'(NUM_REQ - 1);
         grant_oh         <= '0;
         req_ack          <= '0;
         req_done         <= '0;
         router_start_req <= 1'b0;
         router_scr_addr  <= '0;
         router_dst_addr  <= '0;
         router_src_dfx   <= '0;
         router_dst_dfx   <= '0;
`ifdef SEND_ARB_TIMEOUT_EN
         req_err          <= '0;
`endif
      end else begin
         // Pulse outputs default low; states below raise them for one cycle.
         req_ack          <= '0;
         req_done         <= '0;
         router_start_req <= 1'b0;
`ifdef SEND_ARB_TIMEOUT_EN
         req_err          <= '0;
`endif
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  state            <= ISSUE;
                  last_grant       <= pick_idx;
                  grant_oh         <= pick_oh;
                  req_ack          <= pick_oh;
                  router_start_req <= 1'b1;
                  router_scr_addr  <= req_src_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                  router_dst_addr  <= req_dst_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                  router_dst_dfx   <= req_dst_dfx[pick_idx*DFX_WIDTH +: DFX_WIDTH];
                  router_src_dfx   <= local_dfx;
               end
            end
            ISSUE: state <= WAIT_DONE;
            WAIT_DONE: begin
               if (router_send_done) begin
                  state    <= GAP;
                  req_done <= grant_oh;
               end
`ifdef SEND_ARB_TIMEOUT_EN
               else if (expired) begin
                  state   <= GAP;
                  req_err <= grant_oh;
               end
`endif
            end
            GAP:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
